// File: rtl/led_fade_sequencer_pkg.sv
// rtl/led_fade_sequencer_pkg.sv - shared types and defaults for the LED fade sequencer
// Purpose: mode/state enums and default sizes used by the sequencer, its PWM bank and its config interface.
// Ports: none (package).
package led_seq_pkg;

  localparam int CNT_W_DEFAULT = 8;
  localparam int N_LED_DEFAULT = 4;
  localparam int DUTY_MAX      = (1 << CNT_W_DEFAULT) - 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CHASE   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STATIC,
    ST_RAMP_UP,
    ST_RAMP_DN,
    ST_CHASE
  } state_e;

endpackage

// File: rtl/led_fade_sequencer_if.sv
// rtl/led_fade_sequencer_if.sv - valid/ready configuration channel of the LED fade sequencer
// Purpose: carries one config request (mode, duty/limit, breathe step) from board control to the sequencer.
// Signals: cfg_valid (req), cfg_ready (ack), cfg_mode[1:0], cfg_duty[CNT_W], cfg_step[CNT_W].
// Modports: master = requester, slave = sequencer.
interface led_fade_sequencer_if
  import led_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_duty;
  logic [CNT_W-1:0] cfg_step;

  modport master (output cfg_valid, cfg_mode, cfg_duty, cfg_step, input cfg_ready);
  modport slave  (input cfg_valid, cfg_mode, cfg_duty, cfg_step, output cfg_ready);
endinterface

// File: rtl/led_fade_sequencer_pwm_bank.sv
// rtl/led_fade_sequencer_pwm_bank.sv - free-running PWM counter and per-LED comparators
// Purpose: generates N_LED registered PWM outputs from per-LED duty values.
// Ports: clk, rst_n (async active-low), duty[N_LED][CNT_W] in, led[N_LED] out (registered),
//        period_tick out (high while the counter sits at its last value).
module pwm_bank
  import led_seq_pkg::*;
#(
  parameter int N_LED = N_LED_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_LED-1:0][CNT_W-1:0] duty,
  output logic [N_LED-1:0]            led,
  output logic                        period_tick
);
  logic [CNT_W-1:0] cnt;

  // led is registered from cnt < duty, so the cycle after a boundary always sees the
  // comparison against the last count value, which is never below any duty: no partial pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      led <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      for (int i = 0; i < N_LED; i++) begin
        led[i] <= (cnt < duty[i]);
      end
    end
  end

  assign period_tick = &cnt;
endmodule

// File: rtl/led_fade_sequencer.sv
// rtl/led_fade_sequencer.sv - mode FSM and duty sequencer driving a 4-LED PWM bank
// Purpose: accepts config over a valid/ready channel, applies it at the next PWM period boundary and
//          sequences per-LED duty for OFF / STATIC / BREATHE / CHASE.
// Ports: clk, rst_n (async active-low), cfg (slave config channel), led[N_LED] out (registered PWM),
//        period_tick out (1-cycle boundary pulse), busy out (mode != OFF).
module led_fade_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LED        = N_LED_DEFAULT,
  parameter int CNT_W        = CNT_W_DEFAULT,
  parameter int STEP_PERIODS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  led_fade_sequencer_if.slave cfg,
  output logic [N_LED-1:0]    led,
  output logic                period_tick,
  output logic                busy
);
  localparam int SC_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

  state_e                      state, state_nx;
  logic [N_LED-1:0][CNT_W-1:0] duty, duty_nx;
  logic [SC_W-1:0]             step_cnt, step_cnt_nx;
  logic [IDX_W-1:0]            chase_idx, chase_idx_nx;
  logic [CNT_W-1:0]            limit, limit_nx, step, step_nx;
  logic                        step_fire;
  logic [CNT_W:0]              up_sum, dn_diff;

  logic             pend_valid;
  mode_e            pend_mode;
  logic [CNT_W-1:0] pend_duty, pend_step;

  pwm_bank #(.N_LED(N_LED), .CNT_W(CNT_W)) u_pwm (
    .clk         (clk),
    .rst_n       (rst_n),
    .duty        (duty),
    .led         (led),
    .period_tick (period_tick)
  );

  assign cfg.cfg_ready = !pend_valid;

  // Accept has priority over the boundary clear: an accept can only happen while the
  // holding register is empty, so nothing is applied in that boundary anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_mode  <= MODE_OFF;
      pend_duty  <= '0;
      pend_step  <= '0;
    end else if (cfg.cfg_valid && !pend_valid) begin
      pend_valid <= 1'b1;
      pend_mode  <= mode_e'(cfg.cfg_mode);
      pend_duty  <= cfg.cfg_duty;
      pend_step  <= cfg.cfg_step;
    end else if (period_tick) begin
      pend_valid <= 1'b0;
    end
  end

  // State register (with the datapath registers it owns)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      duty      <= '0;
      step_cnt  <= '0;
      chase_idx <= '0;
      limit     <= '0;
      step      <= '0;
    end else begin
      state     <= state_nx;
      duty      <= duty_nx;
      step_cnt  <= step_cnt_nx;
      chase_idx <= chase_idx_nx;
      limit     <= limit_nx;
      step      <= step_nx;
    end
  end

  // One extra bit so the ramp arithmetic can be clamped instead of wrapping.
  assign up_sum  = {1'b0, duty[0]} + {1'b0, step};
  assign dn_diff = {1'b0, duty[0]} - {1'b0, step};

  // Next-state logic: nothing moves except on a boundary cycle.
  always_comb begin
    state_nx     = state;
    duty_nx      = duty;
    step_cnt_nx  = step_cnt;
    chase_idx_nx = chase_idx;
    limit_nx     = limit;
    step_nx      = step;
    step_fire    = 1'b0;
    if (period_tick) begin
      if (pend_valid) begin
        limit_nx     = pend_duty;
        step_nx      = pend_step;
        step_cnt_nx  = '0;
        chase_idx_nx = '0;
        duty_nx      = '0;
        case (pend_mode)
          MODE_OFF:     state_nx = ST_OFF;
          MODE_STATIC: begin
            state_nx = ST_STATIC;
            for (int i = 0; i < N_LED; i++) duty_nx[i] = pend_duty;
          end
          MODE_BREATHE: state_nx = ST_RAMP_UP;
          default: begin
            state_nx   = ST_CHASE;
            duty_nx[0] = pend_duty;
          end
        endcase
      end else begin
        step_fire   = (step_cnt == SC_W'(STEP_PERIODS - 1));
        step_cnt_nx = step_fire ? '0 : step_cnt + SC_W'(1);
        if (step_fire) begin
          case (state)
            ST_RAMP_UP: begin
              if (step != '0) begin
                if (up_sum >= {1'b0, limit}) begin
                  for (int i = 0; i < N_LED; i++) duty_nx[i] = limit;
                  state_nx = ST_RAMP_DN;
                end else begin
                  for (int i = 0; i < N_LED; i++) duty_nx[i] = up_sum[CNT_W-1:0];
                end
              end
            end
            ST_RAMP_DN: begin
              if (step != '0) begin
                if (dn_diff[CNT_W] || dn_diff == '0) begin
                  duty_nx  = '0;
                  state_nx = ST_RAMP_UP;
                end else begin
                  for (int i = 0; i < N_LED; i++) duty_nx[i] = dn_diff[CNT_W-1:0];
                end
              end
            end
            ST_CHASE: begin
              chase_idx_nx          = (chase_idx == IDX_W'(N_LED - 1)) ? '0 : chase_idx + IDX_W'(1);
              duty_nx               = '0;
              duty_nx[chase_idx_nx] = limit;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Output logic
  always_comb begin
    busy = (state != ST_OFF);
  end
endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb/tb_led_fade_sequencer.sv - self-checking bench for led_fade_sequencer
module tb_led_fade_sequencer;
  import led_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led;
  logic       period_tick;
  logic       busy;

  always #5 clk = ~clk;

  led_fade_sequencer_if #(.CNT_W(8)) cfg_if ();

  led_fade_sequencer #(.N_LED(4), .CNT_W(8), .STEP_PERIODS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if),
    .led         (led),
    .period_tick (period_tick),
    .busy        (busy)
  );

  typedef logic [0:9][8:0] seq_t;
  typedef struct {
    logic [1:0] mode;
    logic [7:0] duty;
    logic [7:0] step;
    int         n_steps;
    bit         chase;
    seq_t       exp;
  } vec_t;

  typedef struct {
    int              period;
    logic [3:0][8:0] on;
  } sb_t;

  vec_t vecs [7];
  sb_t  sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int tick_err = 0;
  int acc [4];

  logic [7:0] ref_cnt;
  int         ref_period;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference PWM position, independent of the DUT counter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt    <= 8'd0;
      ref_period <= 0;
    end else begin
      ref_cnt <= ref_cnt + 8'd1;
      if (ref_cnt == 8'd255) ref_period <= ref_period + 1;
    end
  end

  // Monitor: count LED on-cycles per period and compare with the scoreboard.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc[i] = 0;
    end else begin
      if (period_tick !== (ref_cnt == 8'd255)) tick_err++;
      if (ref_cnt != 8'd0)
        for (int i = 0; i < 4; i++) if (led[i]) acc[i]++;
      if (ref_cnt == 8'd255) begin
        while (sb_q.size() > 0 && sb_q[0].period < ref_period) begin
          check($sformatf("missed_p%0d", sb_q[0].period), 1, 0);
          void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].period == ref_period) begin
          e = sb_q.pop_front();
          for (int i = 0; i < 4; i++)
            check($sformatf("p%0d_led%0d_on", ref_period, i), acc[i], int'(e.on[i]));
        end
        for (int i = 0; i < 4; i++) acc[i] = 0;
      end
    end
  end

  task automatic push_const(input int per, input int val);
    sb_t e;
    e.period = per;
    for (int i = 0; i < 4; i++) e.on[i] = 9'(val);
    sb_q.push_back(e);
  endtask

  task automatic send_cfg(input logic [1:0] m, input logic [7:0] d, input logic [7:0] s, output int first);
    int c, p, guard;
    @(negedge clk);
    guard = 0;
    while (!cfg_if.cfg_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    cfg_if.cfg_mode  = m;
    cfg_if.cfg_duty  = d;
    cfg_if.cfg_step  = s;
    cfg_if.cfg_valid = 1'b1;
    c = int'(ref_cnt);
    p = ref_period;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    check("cfg_ready_drop", int'(cfg_if.cfg_ready), 0);
    first = p + 1 + ((c == 255) ? 1 : 0);
  endtask

  task automatic wait_past(input int last);
    int guard = 0;
    while (ref_period <= last && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("wait_past_p%0d", last), int'(ref_period > last), 1);
  endtask

  initial begin
    int first, p, guard, dummy;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode  = 2'd0;
    cfg_if.cfg_duty  = 8'd0;
    cfg_if.cfg_step  = 8'd0;

    vecs[0] = '{2'd1, 8'd20,  8'd0,  2,  1'b0, {9'd20, 9'd20, 72'd0}};
    vecs[1] = '{2'd2, 8'd200, 8'd64, 10, 1'b0,
                {9'd0, 9'd64, 9'd128, 9'd192, 9'd200, 9'd136, 9'd72, 9'd8, 9'd0, 9'd64}};
    vecs[2] = '{2'd3, 8'd255, 8'd0,  5,  1'b1, {9'd255, 9'd255, 9'd255, 9'd255, 9'd255, 45'd0}};
    vecs[3] = '{2'd2, 8'd100, 8'd0,  3,  1'b0, {90'd0}};
    vecs[4] = '{2'd2, 8'd0,   8'd50, 3,  1'b0, {90'd0}};
    vecs[5] = '{2'd1, 8'd255, 8'd0,  1,  1'b0, {9'd255, 81'd0}};
    vecs[6] = '{2'd0, 8'd77,  8'd5,  2,  1'b0, {90'd0}};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    check("rst_period_tick", int'(period_tick), 0);
    rst_n = 1'b1;
    push_const(0, 0);

    for (int v = 0; v < 7; v++) begin
      send_cfg(vecs[v].mode, vecs[v].duty, vecs[v].step, first);
      for (int s = 0; s < vecs[v].n_steps; s++) begin
        for (int k = 0; k < 4; k++) begin
          sb_t e;
          e.period = first + 4 * s + k;
          for (int i = 0; i < 4; i++)
            e.on[i] = (!vecs[v].chase || i == (s % 4)) ? vecs[v].exp[s] : 9'd0;
          sb_q.push_back(e);
        end
      end
      wait_past(first + 4 * vecs[v].n_steps - 1);
      check($sformatf("vec%0d_busy", v), int'(busy), (vecs[v].mode != 2'd0) ? 1 : 0);
      check($sformatf("vec%0d_cfg_ready", v), int'(cfg_if.cfg_ready), 1);
    end

    // Request in the boundary cycle itself; a second request while not ready is dropped.
    guard = 0;
    while (ref_cnt != 8'd255 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    p = ref_period;
    cfg_if.cfg_mode  = 2'd1;
    cfg_if.cfg_duty  = 8'd40;
    cfg_if.cfg_step  = 8'd0;
    cfg_if.cfg_valid = 1'b1;
    @(negedge clk);
    check("hs_ready_low", int'(cfg_if.cfg_ready), 0);
    cfg_if.cfg_duty = 8'd99;
    repeat (3) @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    push_const(p + 1, 0);
    push_const(p + 2, 40);
    push_const(p + 3, 40);
    guard = 0;
    while (!(ref_period == p + 1 && ref_cnt == 8'd255) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("hs_ready_in_apply", int'(cfg_if.cfg_ready), 0);
    @(negedge clk);
    check("hs_ready_after_apply", int'(cfg_if.cfg_ready), 1);
    check("hs_busy", int'(busy), 1);
    wait_past(p + 3);

    // Asynchronous reset in the middle of BREATHE with a config still pending.
    send_cfg(2'd2, 8'd200, 8'd64, first);
    for (int k = 0; k < 4; k++) push_const(first + k, 0);
    guard = 0;
    while (!(ref_period == first + 4 && ref_cnt == 8'd10) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_led", int'(led), 15);
    check("pre_rst_busy", int'(busy), 1);
    send_cfg(2'd1, 8'd255, 8'd0, dummy);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_led", int'(led), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    check("async_rst_period_tick", int'(period_tick), 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_const(0, 0);
    push_const(1, 0);
    push_const(2, 0);
    wait_past(2);
    check("post_rst_busy", int'(busy), 0);

    check("period_tick_align", tick_err, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
